// File: rtl/mem_adapter_pkg.sv
// rtl/mem_adapter_pkg.sv - shared types and constants for the read-modify-write memory adapter
package mem_adapter_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_BAD  = 2'd3
   } size_e;

   localparam logic [1:0] FAULT_NONE     = 2'd0;
   localparam logic [1:0] FAULT_MISALIGN = 2'd1;
   localparam logic [1:0] FAULT_READ     = 2'd2;
   localparam logic [1:0] FAULT_WRITE    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   // Bits of the 32-bit word touched by an access of the given size at byte offset off.
   function automatic logic [31:0] lane_mask(input size_e sz, input logic [1:0] off);
      logic [31:0] m;
      case (sz)
         SZ_BYTE: m = 32'h0000_00FF << {off, 3'b000};
         SZ_HALF: m = 32'h0000_FFFF << {off, 3'b000};
         default: m = 32'hFFFF_FFFF;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_rmw_adapter_if.sv
// rtl/mem_rmw_adapter_if.sv - core request/response and memory port bundle of the adapter
interface mem_rmw_adapter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [1:0]            req_size;
   logic                  req_signed;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [31:0]           req_wdata;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [31:0]           rsp_rdata;
   logic                  rsp_fault;
   logic [1:0]            rsp_fault_code;

   logic [ADDR_WIDTH-1:0] mem_read_address;
   logic [31:0]           mem_read_data;
   logic                  mem_read_exception;
   logic                  mem_write_enable;
   logic [ADDR_WIDTH-1:0] mem_write_address;
   logic [31:0]           mem_write_data;
   logic                  mem_write_exception;

   // master: core plus memory environment; slave: the adapter itself
   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output mem_read_data, mem_read_exception, mem_write_exception,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code,
      input  mem_read_address, mem_write_enable, mem_write_address, mem_write_data
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  mem_read_data, mem_read_exception, mem_write_exception,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_fault_code,
      output mem_read_address, mem_write_enable, mem_write_address, mem_write_data
   );

endinterface

// File: rtl/mem_lane_merge.sv
// rtl/mem_lane_merge.sv - byte-lane merge for sub-word stores and lane extract/extend for loads
module mem_lane_merge
   import mem_adapter_pkg::*;
(
   input  size_e       size_i,
   input  logic [1:0]  offset_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] merged_o,
   output logic [31:0] load_o
);

   logic [4:0]  shamt;
   logic [31:0] mask;
   logic [31:0] shifted;

   always_comb begin
      shamt    = {offset_i, 3'b000};
      mask     = lane_mask(size_i, offset_i);
      merged_o = (rdata_i & ~mask) | ((wdata_i << shamt) & mask);
      shifted  = rdata_i >> shamt;
      case (size_i)
         SZ_BYTE: load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
         SZ_HALF: load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
         default: load_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_rmw_adapter.sv
// rtl/mem_rmw_adapter.sv - load/store front-end issuing whole-word memory accesses, RMW for sub-word stores
module mem_rmw_adapter
   import mem_adapter_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int ALIGN_BYTES = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   mem_rmw_adapter_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] GRAN_MASK = ADDR_WIDTH'(ALIGN_BYTES - 1);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   size_e                 size_q, size_d;
   logic [1:0]            off_q, off_d;
   logic                  signed_q, signed_d;
   logic                  write_q, write_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  fault_q, fault_d;
   logic [1:0]            code_q, code_d;

   size_e                 req_size;
   logic [1:0]            req_off;
   logic                  misaligned;
   logic [31:0]           merged_word;
   logic [31:0]           load_word;

   mem_lane_merge u_lane_merge (
      .size_i   (size_q),
      .offset_i (off_q),
      .signed_i (signed_q),
      .wdata_i  (wdata_q),
      .rdata_i  (bus.mem_read_data),
      .merged_o (merged_word),
      .load_o   (load_word)
   );

   // Upper half of each granule is unreachable: the memory faults any non-granule-aligned word.
   always_comb begin
      req_size   = size_e'(bus.req_size);
      req_off    = bus.req_addr[1:0];
      misaligned = (req_size == SZ_BAD)
                 || (req_size == SZ_HALF && req_off[0])
                 || (req_size == SZ_WORD && req_off != 2'd0)
                 || ((bus.req_addr & GRAN_MASK) >= ADDR_WIDTH'(4));
   end

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      size_d   = size_q;
      off_d    = off_q;
      signed_d = signed_q;
      write_d  = write_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      code_d   = code_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               base_d   = bus.req_addr & ~GRAN_MASK;
               size_d   = req_size;
               off_d    = req_off;
               signed_d = bus.req_signed;
               write_d  = bus.req_write;
               wdata_d  = bus.req_wdata;
               rdata_d  = '0;
               fault_d  = 1'b0;
               code_d   = FAULT_NONE;
               if (misaligned) begin
                  fault_d = 1'b1;
                  code_d  = FAULT_MISALIGN;
                  state_d = ST_RESP;
               end else if (bus.req_write && req_size == SZ_WORD) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (bus.mem_read_exception) begin
               fault_d = 1'b1;
               code_d  = FAULT_READ;
               state_d = ST_RESP;
            end else if (write_q) begin
               // wdata_q now carries the merged word that WRITE drives out
               wdata_d = merged_word;
               state_d = ST_WRITE;
            end else begin
               rdata_d = load_word;
               state_d = ST_RESP;
            end
         end
         ST_WRITE: begin
            if (bus.mem_write_exception) begin
               fault_d = 1'b1;
               code_d  = FAULT_WRITE;
            end
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         base_q   <= '0;
         size_q   <= SZ_BYTE;
         off_q    <= 2'd0;
         signed_q <= 1'b0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
         code_q   <= FAULT_NONE;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         size_q   <= size_d;
         off_q    <= off_d;
         signed_q <= signed_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
      end
   end

   assign bus.req_ready         = (state_q == ST_IDLE);
   assign bus.rsp_valid         = (state_q == ST_RESP);
   assign bus.rsp_rdata         = rdata_q;
   assign bus.rsp_fault         = fault_q;
   assign bus.rsp_fault_code    = code_q;
   assign bus.mem_read_address  = base_q;
   assign bus.mem_write_address = base_q;
   assign bus.mem_write_data    = wdata_q;
   assign bus.mem_write_enable  = (state_q == ST_WRITE) && !bus.mem_write_exception;

endmodule

// File: tb/tb_mem_rmw_adapter.sv
// tb/tb_mem_rmw_adapter.sv - directed self-checking bench for mem_rmw_adapter
module tb_mem_rmw_adapter;

   logic clk;
   logic reset_n;
   int   total = 0;
   int   bad   = 0;
   int   lat;
   int   w0;

   int          wr_count  = 0;
   int          wr_consec = 0;
   logic        prev_we   = 1'b0;
   logic [31:0] wr_addr   = '0;
   logic [31:0] wr_data   = '0;

   mem_rmw_adapter_if #(.ADDR_WIDTH(32)) bus ();

   mem_rmw_adapter #(.ADDR_WIDTH(32), .ALIGN_BYTES(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (bus.mem_write_enable === 1'b1) begin
         wr_count = wr_count + 1;
         wr_addr  = bus.mem_write_address;
         wr_data  = bus.mem_write_data;
         if (prev_we) wr_consec = wr_consec + 1;
      end
      prev_we = (bus.mem_write_enable === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
      chk("req_ready_before", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_write  = w;
      bus.req_size   = sz;
      bus.req_signed = sg;
      bus.req_addr   = a;
      bus.req_wdata  = d;
      @(negedge clk);
      bus.req_valid  = 1'b0;
   endtask

   task automatic wait_rsp(output int l);
      l = 1;
      while (bus.rsp_valid !== 1'b1 && l < 20) begin
         @(negedge clk);
         l = l + 1;
      end
   endtask

   task automatic take_rsp();
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      bus.req_valid           = 1'b0;
      bus.req_write           = 1'b0;
      bus.req_size            = 2'd0;
      bus.req_signed          = 1'b0;
      bus.req_addr            = '0;
      bus.req_wdata           = '0;
      bus.rsp_ready           = 1'b0;
      bus.mem_read_data       = '0;
      bus.mem_read_exception  = 1'b0;
      bus.mem_write_exception = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
      chk("rst_rsp_code", 32'(bus.rsp_fault_code), 32'd0);
      chk("rst_we", 32'(bus.mem_write_enable), 32'd0);
      chk("rst_rd_addr", bus.mem_read_address, 32'd0);
      chk("rst_wr_addr", bus.mem_write_address, 32'd0);
      chk("rst_wr_data", bus.mem_write_data, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // word load
      bus.mem_read_data = 32'hDEAD_BEEF;
      send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      chk("t1_rd_addr", bus.mem_read_address, 32'h10);
      wait_rsp(lat);
      chk("t1_latency", 32'(lat), 32'd2);
      chk("t1_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_fault", 32'(bus.rsp_fault), 32'd0);
      chk("t1_code", 32'(bus.rsp_fault_code), 32'd0);
      take_rsp();
      chk("t1_ready_after", 32'(bus.req_ready), 32'd1);

      // byte/half loads with extension
      bus.mem_read_data = 32'h80FF_1234;
      send(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
      wait_rsp(lat);
      chk("t2_sbyte", bus.rsp_rdata, 32'hFFFF_FF80);
      take_rsp();
      send(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
      wait_rsp(lat);
      chk("t2_ubyte", bus.rsp_rdata, 32'h0000_0080);
      take_rsp();
      send(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
      wait_rsp(lat);
      chk("t2_shalf", bus.rsp_rdata, 32'hFFFF_80FF);
      take_rsp();
      send(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
      wait_rsp(lat);
      chk("t2_uhalf", bus.rsp_rdata, 32'h0000_1234);
      take_rsp();

      // byte store read-modify-write
      bus.mem_read_data = 32'h1122_3344;
      w0 = wr_count;
      send(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
      wait_rsp(lat);
      chk("t3_latency", 32'(lat), 32'd3);
      chk("t3_strobes", 32'(wr_count - w0), 32'd1);
      chk("t3_wr_addr", wr_addr, 32'h10);
      chk("t3_wr_data", wr_data, 32'h1122_AB44);
      chk("t3_rdata", bus.rsp_rdata, 32'd0);
      chk("t3_fault", 32'(bus.rsp_fault), 32'd0);
      take_rsp();

      // half store in second half-word of granule 0x18
      w0 = wr_count;
      send(1'b1, 2'd1, 1'b0, 32'h1A, 32'h0000_BEEF);
      wait_rsp(lat);
      chk("t3h_strobes", 32'(wr_count - w0), 32'd1);
      chk("t3h_wr_addr", wr_addr, 32'h18);
      chk("t3h_wr_data", wr_data, 32'hBEEF_3344);
      take_rsp();

      // word store skips READ
      w0 = wr_count;
      send(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFE_F00D);
      wait_rsp(lat);
      chk("t3w_latency", 32'(lat), 32'd2);
      chk("t3w_strobes", 32'(wr_count - w0), 32'd1);
      chk("t3w_wr_addr", wr_addr, 32'h20);
      chk("t3w_wr_data", wr_data, 32'hCAFE_F00D);
      take_rsp();

      // misalignment faults
      w0 = wr_count;
      send(1'b1, 2'd1, 1'b0, 32'h01, 32'h0000_5555);
      wait_rsp(lat);
      chk("t4_half_latency", 32'(lat), 32'd1);
      chk("t4_half_fault", 32'(bus.rsp_fault), 32'd1);
      chk("t4_half_code", 32'(bus.rsp_fault_code), 32'd1);
      chk("t4_half_strobes", 32'(wr_count - w0), 32'd0);
      take_rsp();
      send(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);
      wait_rsp(lat);
      chk("t4_gran_code", 32'(bus.rsp_fault_code), 32'd1);
      chk("t4_gran_rdata", bus.rsp_rdata, 32'd0);
      take_rsp();
      send(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
      wait_rsp(lat);
      chk("t4_size3_code", 32'(bus.rsp_fault_code), 32'd1);
      take_rsp();

      // memory faults
      w0 = wr_count;
      bus.mem_read_exception = 1'b1;
      send(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
      wait_rsp(lat);
      bus.mem_read_exception = 1'b0;
      chk("t5_rd_latency", 32'(lat), 32'd2);
      chk("t5_rd_code", 32'(bus.rsp_fault_code), 32'd2);
      chk("t5_rd_strobes", 32'(wr_count - w0), 32'd0);
      take_rsp();
      bus.mem_read_exception = 1'b1;
      send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      wait_rsp(lat);
      bus.mem_read_exception = 1'b0;
      chk("t5_ld_code", 32'(bus.rsp_fault_code), 32'd2);
      chk("t5_ld_rdata", bus.rsp_rdata, 32'd0);
      take_rsp();
      w0 = wr_count;
      bus.mem_write_exception = 1'b1;
      send(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678);
      wait_rsp(lat);
      bus.mem_write_exception = 1'b0;
      chk("t5_wr_fault", 32'(bus.rsp_fault), 32'd1);
      chk("t5_wr_code", 32'(bus.rsp_fault_code), 32'd3);
      chk("t5_wr_strobes", 32'(wr_count - w0), 32'd0);
      take_rsp();

      // reset during READ of a sub-word store
      bus.mem_read_data = 32'h1122_3344;
      w0 = wr_count;
      send(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("t6_rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("t6_rst_strobes", 32'(wr_count - w0), 32'd0);

      // response held while rsp_ready low
      bus.mem_read_data = 32'hDEAD_BEEF;
      send(1'b0, 2'd2, 1'b0, 32'h18, 32'h0);
      wait_rsp(lat);
      bus.mem_read_data = 32'h0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("t6_hold_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
         chk("t6_hold_code", 32'(bus.rsp_fault_code), 32'd0);
      end
      take_rsp();
      chk("t6_released", 32'(bus.rsp_valid), 32'd0);
      chk("we_never_consecutive", 32'(wr_consec), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
